issue_queue: RTL

Parametrised successor to the single-slot issuer: a DEPTH-entry in-order queue of pre-decoded instructions between the instruction fetcher and the reorder buffer / reservation station / load-store buffer. Each cycle it issues at most one instruction from the head, allocating the ROB tag and resolving operands. Operands resolve from the register file, the ROB, or NUM_BUS result buses. It also forwards the rename of the instruction issued in the previous cycle, closing the one-cycle register-file rename gap. A ROB flush empties the queue.

---
 rtl/issue_queue.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// issue_queue: DEPTH-entry in-order queue of pre-decoded instructions.
// Issues at most one instruction per cycle from the head, resolving its
// operands from the register file, the ROB, the result buses, or the
// rename made by the instruction issued in the previous cycle.
module issue_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_BUS = 2,
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     is_any_full,
  input  logic                     reset_from_rob_bus,
  input  logic                     valid_from_inst_fetcher,
  output logic                     ready_to_inst_fetcher,
  input  logic [OP_W-1:0]          op_in,
  input  logic [4:0]               rd_in,
  input  logic [4:0]               rs1_in,
  input  logic [4:0]               rs2_in,
  input  logic [XLEN-1:0]          imm_in,
  input  logic [1:0]               kind_in,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [XLEN-1:0]          next_pc_in,
  output logic [4:0]               rs1_to_reg_file,
  output logic [4:0]               rs2_to_reg_file,
  input  logic [XLEN-1:0]          vj_from_reg_file,
  input  logic [XLEN-1:0]          vk_from_reg_file,
  input  logic [ROB_W-1:0]         qj_from_reg_file,
  input  logic [ROB_W-1:0]         qk_from_reg_file,
  output logic [ROB_W-1:0]         qj_to_ro_buffer,
  output logic [ROB_W-1:0]         qk_to_ro_buffer,
  input  logic                     valid_of_vj_from_ro_buffer,
  input  logic                     valid_of_vk_from_ro_buffer,
  input  logic [XLEN-1:0]          vj_from_ro_buffer,
  input  logic [XLEN-1:0]          vk_from_ro_buffer,
  input  logic [ROB_W-1:0]         dest_from_ro_buffer,
  input  logic [NUM_BUS*ROB_W-1:0] bus_dest,
  input  logic [NUM_BUS*XLEN-1:0]  bus_value,
  output logic                     issue_valid,
  output logic [1:0]               issue_kind,
  output logic [OP_W-1:0]          issue_op,
  output logic [4:0]               issue_rd,
  output logic [ROB_W-1:0]         issue_dest,
  output logic [ROB_W-1:0]         issue_qj,
  output logic [ROB_W-1:0]         issue_qk,
  output logic [XLEN-1:0]          issue_vj,
  output logic [XLEN-1:0]          issue_vk,
  output logic [XLEN-1:0]          issue_imm,
  output logic [XLEN-1:0]          issue_pc,
  output logic [XLEN-1:0]          issue_next_pc,
  output logic [4:0]               rd_to_reg_file,
  output logic [ROB_W-1:0]         dest_to_reg_file
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd3;

  logic [OP_W-1:0] r_opMem   [DEPTH];
  logic [4:0]      r_rdMem   [DEPTH];
  logic [4:0]      r_rs1Mem  [DEPTH];
  logic [4:0]      r_rs2Mem  [DEPTH];
  logic [XLEN-1:0] r_immMem  [DEPTH];
  logic [1:0]      r_kindMem [DEPTH];
  logic [XLEN-1:0] r_pcMem   [DEPTH];
  logic [XLEN-1:0] r_npcMem  [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             r_lastFire;
  logic [4:0]       r_lastRd;
  logic [ROB_W-1:0] r_lastDest;

  logic                  w_notEmpty;
  logic                  w_enq;
  logic                  w_fire;
  logic [4:0]            w_headRd;
  logic [4:0]            w_headRdEff;
  logic [1:0]            w_headKind;
  logic [ROB_W+XLEN-1:0] w_opJ;
  logic [ROB_W+XLEN-1:0] w_opK;

  // Picks the operand source in priority order: previous-cycle rename,
  // ready register file value, ROB value, then the lowest-index bus whose
  // tag matches. Returns {tag, value}; a zero tag means the value is ready.
  function automatic logic [ROB_W+XLEN-1:0] resolveOperand(
    input logic [4:0]               rs,
    input logic [ROB_W-1:0]         qReg,
    input logic [XLEN-1:0]          vReg,
    input logic                     robValid,
    input logic [XLEN-1:0]          vRob,
    input logic                     lastFire,
    input logic [4:0]               lastRd,
    input logic [ROB_W-1:0]         lastDest,
    input logic [NUM_BUS*ROB_W-1:0] busDest,
    input logic [NUM_BUS*XLEN-1:0]  busValue
  );
    logic [ROB_W+XLEN-1:0] result;
    logic                  found;
    result = {qReg, vReg};
    found  = 1'b0;
    if (lastFire && (lastRd != 5'd0) && (rs == lastRd)) begin
      result = {lastDest, {XLEN{1'b0}}};
    end else if (qReg == {ROB_W{1'b0}}) begin
      result = {{ROB_W{1'b0}}, vReg};
    end else if (robValid) begin
      result = {{ROB_W{1'b0}}, vRob};
    end else begin
      for (int i = 0; i < NUM_BUS; i++) begin
        if (!found && (busDest[i*ROB_W +: ROB_W] == qReg)) begin
          result = {{ROB_W{1'b0}}, busValue[i*XLEN +: XLEN]};
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

  assign w_notEmpty = (r_count != {CNT_W{1'b0}});
  assign ready_to_inst_fetcher = (r_count < FULL_COUNT);

  assign w_enq  = valid_from_inst_fetcher && ready_to_inst_fetcher && rdy && !reset_from_rob_bus;
  assign w_fire = w_notEmpty && !is_any_full && rdy && !reset_from_rob_bus;

  assign w_headRd    = r_rdMem[r_head];
  assign w_headKind  = r_kindMem[r_head];
  assign w_headRdEff = ((w_headKind == KIND_BRANCH) || (w_headKind == KIND_STORE)) ? 5'd0 : w_headRd;

  assign rs1_to_reg_file = w_notEmpty ? r_rs1Mem[r_head] : 5'd0;
  assign rs2_to_reg_file = w_notEmpty ? r_rs2Mem[r_head] : 5'd0;
  assign qj_to_ro_buffer = qj_from_reg_file;
  assign qk_to_ro_buffer = qk_from_reg_file;

  assign w_opJ = resolveOperand(rs1_to_reg_file, qj_from_reg_file, vj_from_reg_file,
                                valid_of_vj_from_ro_buffer, vj_from_ro_buffer,
                                r_lastFire, r_lastRd, r_lastDest, bus_dest, bus_value);
  assign w_opK = resolveOperand(rs2_to_reg_file, qk_from_reg_file, vk_from_reg_file,
                                valid_of_vk_from_ro_buffer, vk_from_ro_buffer,
                                r_lastFire, r_lastRd, r_lastDest, bus_dest, bus_value);

  // Entry storage is written at the tail on accept; it needs no reset since
  // only slots covered by the count are ever observed.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_opMem[r_tail]   <= op_in;
      r_rdMem[r_tail]   <= rd_in;
      r_rs1Mem[r_tail]  <= rs1_in;
      r_rs2Mem[r_tail]  <= rs2_in;
      r_immMem[r_tail]  <= imm_in;
      r_kindMem[r_tail] <= kind_in;
      r_pcMem[r_tail]   <= pc_in;
      r_npcMem[r_tail]  <= next_pc_in;
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (reset_from_rob_bus) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_fire) r_head <= r_head + PTR_W'(1);
      if (w_enq && !w_fire) r_count <= r_count + CNT_W'(1);
      else if (!w_enq && w_fire) r_count <= r_count - CNT_W'(1);
    end
  end

  // Issue outputs and the one-cycle rename memory used for forwarding to the
  // next instruction before the register file has seen the rename.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid      <= 1'b0;
      issue_kind       <= '0;
      issue_op         <= '0;
      issue_rd         <= '0;
      issue_dest       <= '0;
      issue_qj         <= '0;
      issue_qk         <= '0;
      issue_vj         <= '0;
      issue_vk         <= '0;
      issue_imm        <= '0;
      issue_pc         <= '0;
      issue_next_pc    <= '0;
      rd_to_reg_file   <= '0;
      dest_to_reg_file <= '0;
      r_lastFire       <= 1'b0;
      r_lastRd         <= '0;
      r_lastDest       <= '0;
    end else begin
      issue_valid    <= w_fire;
      rd_to_reg_file <= w_fire ? w_headRdEff : 5'd0;
      r_lastFire     <= w_fire;
      r_lastRd       <= w_headRdEff;
      r_lastDest     <= dest_from_ro_buffer;
      if (w_fire) begin
        issue_kind       <= w_headKind;
        issue_op         <= r_opMem[r_head];
        issue_rd         <= w_headRd;
        issue_dest       <= dest_from_ro_buffer;
        issue_qj         <= w_opJ[ROB_W+XLEN-1:XLEN];
        issue_vj         <= w_opJ[XLEN-1:0];
        issue_qk         <= w_opK[ROB_W+XLEN-1:XLEN];
        issue_vk         <= w_opK[XLEN-1:0];
        issue_imm        <= r_immMem[r_head];
        issue_pc         <= r_pcMem[r_head];
        issue_next_pc    <= r_npcMem[r_head];
        dest_to_reg_file <= dest_from_ro_buffer;
      end
    end
  end

endmodule
